// File: rtl/alu_operand_stage.sv
// ALU operand stage: forwards bypass results into rs1/rs2, selects ALU operands,
// and registers them behind a valid/ready handshake with load-use stall detection.
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int NSRC = 3,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           asel,
  input  logic [1:0]           bsel,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic [XLEN-1:0]      imm,
  input  logic [XLEN-1:0]      pc,
  input  logic [4:0]           shamt,
  input  logic [NSRC-1:0]      src_we,
  input  logic [NSRC-1:0]      src_pending,
  input  logic [5*NSRC-1:0]    src_rd,
  input  logic [XLEN*NSRC-1:0] src_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      op_a,
  output logic [XLEN-1:0]      op_b,
  output logic [XLEN-1:0]      st_data,
  output logic [CNTW-1:0]      stall_cnt
);

  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic            rs1_pend, rs2_pend;
  logic            hazard, accept;
  logic [XLEN-1:0] op_a_nxt, op_b_nxt;

  // Scan oldest to youngest so the lowest matching index is written last and wins.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    rs1_fwd  = rs1_data;
    rs2_fwd  = rs2_data;
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_we[i] && (rs1_addr != 5'd0) && (src_rd[5*i +: 5] == rs1_addr)) begin
        rs1_fwd  = src_data[XLEN*i +: XLEN];
        rs1_pend = src_pending[i];
      end
      if (src_we[i] && (rs2_addr != 5'd0) && (src_rd[5*i +: 5] == rs2_addr)) begin
        rs2_fwd  = src_data[XLEN*i +: XLEN];
        rs2_pend = src_pending[i];
      end
    end
  end

  // rs2 always feeds st_data, so a pending rs2 stalls regardless of bsel.
  assign hazard   = ((asel == 2'b11) && rs1_pend) || rs2_pend;
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    op_a_nxt = '0;
    op_b_nxt = '0;
    case (asel)
      2'b00:   op_a_nxt = '0;
      2'b11:   op_a_nxt = rs1_fwd;
      default: op_a_nxt = pc;
    endcase
    case (bsel)
      2'b00:   op_b_nxt = XLEN'(shamt);
      2'b01:   op_b_nxt = rs2_fwd;
      default: op_b_nxt = imm;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: data registers are reset too; downstream observes zeros, not stale operands, after reset.
      out_valid <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      st_data   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      op_a      <= op_a_nxt;
      op_b      <= op_b_nxt;
      st_data   <= rs2_fwd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && hazard && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: a cycle model checked every negedge,
// plus directed scenarios with literal expectations.
module tb_alu_operand_stage;

  localparam int XLEN = 32;
  localparam int NSRC = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, in_ready2;
  logic [1:0]        asel, bsel;
  logic [4:0]        rs1_addr, rs2_addr, shamt;
  logic [XLEN-1:0]   rs1_data, rs2_data, imm, pc;
  logic [NSRC-1:0]   src_we, src_pending;
  logic [5*NSRC-1:0] src_rd;
  logic [XLEN*NSRC-1:0] src_data;
  logic              flush, out_ready;
  logic              out_valid, out_valid2;
  logic [XLEN-1:0]   op_a, op_b, st_data, op_a2, op_b2, st_data2;
  logic [15:0]       stall_cnt;
  logic [1:0]        stall_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(XLEN), .NSRC(NSRC), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .asel(asel), .bsel(bsel), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc), .shamt(shamt),
    .src_we(src_we), .src_pending(src_pending), .src_rd(src_rd), .src_data(src_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b), .st_data(st_data), .stall_cnt(stall_cnt)
  );

  alu_operand_stage #(.XLEN(XLEN), .NSRC(NSRC), .CNTW(2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .asel(asel), .bsel(bsel), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc), .shamt(shamt),
    .src_we(src_we), .src_pending(src_pending), .src_rd(src_rd), .src_data(src_data),
    .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
    .op_a(op_a2), .op_b(op_b2), .st_data(st_data2), .stall_cnt(stall_cnt2)
  );

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic            m_valid = 1'b0;
  logic [XLEN-1:0] m_a = '0, m_b = '0, m_st = '0;
  int              m_cnt = 0, m_cnt2 = 0;

  // Value an operand reads: first (youngest) bypass writing that register, else the register file.
  function automatic void lookup(input logic [4:0] addr, input logic [XLEN-1:0] rf,
                                 output logic [XLEN-1:0] val, output logic pend);
    val  = rf;
    pend = 1'b0;
    if (addr != 0) begin
      for (int i = 0; i < NSRC; i++) begin
        if (src_we[i] && src_rd[5*i +: 5] == addr) begin
          val  = src_data[XLEN*i +: XLEN];
          pend = src_pending[i];
          break;
        end
      end
    end
  endfunction

  function automatic logic m_hazard();
    logic [XLEN-1:0] v1, v2;
    logic            p1, p2;
    lookup(rs1_addr, rs1_data, v1, p1);
    lookup(rs2_addr, rs2_data, v2, p2);
    return (asel == 2'b11 && p1) || p2;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [XLEN-1:0] v1, v2;
    logic            p1, p2, hz, acc;
    if (rst) begin
      m_valid = 1'b0; m_a = '0; m_b = '0; m_st = '0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      lookup(rs1_addr, rs1_data, v1, p1);
      lookup(rs2_addr, rs2_data, v2, p2);
      hz  = (asel == 2'b11 && p1) || p2;
      acc = in_valid && (!m_valid || out_ready) && !hz && !flush;
      if (in_valid && hz && !flush) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_cnt2 < 3)    m_cnt2 = m_cnt2 + 1;
      end
      if (flush) m_valid = 1'b0;
      else if (acc) begin
        m_valid = 1'b1;
        m_a  = (asel == 2'b00) ? '0 : (asel == 2'b11) ? v1 : pc;
        m_b  = (bsel == 2'b00) ? {27'd0, shamt} : (bsel == 2'b01) ? v2 : imm;
        m_st = v2;
      end else if (out_ready) m_valid = 1'b0;
    end
  end

  // Continuous comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    logic exp_ready;
    exp_ready = (!m_valid || out_ready) && !m_hazard();
    check("m_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("m_in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    check("m_stall_cnt", {16'd0, stall_cnt}, m_cnt);
    check("m_stall_cnt2", {30'd0, stall_cnt2}, m_cnt2);
    if (m_valid || rst) begin
      check("m_op_a", op_a, m_a);
      check("m_op_b", op_b, m_b);
      check("m_st_data", st_data, m_st);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic we, input logic pend,
                         input logic [4:0] rd, input logic [XLEN-1:0] data);
    src_we[i]                 = we;
    src_pending[i]            = pend;
    src_rd[5*i +: 5]          = rd;
    src_data[XLEN*i +: XLEN]  = data;
  endtask

  task automatic clear_srcs();
    src_we = '0; src_pending = '0; src_rd = '0; src_data = '0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; asel = 0; bsel = 0; rs1_addr = 0; rs2_addr = 0;
    rs1_data = 0; rs2_data = 0; imm = 0; pc = 0; shamt = 0;
    flush = 0; out_ready = 1;
    clear_srcs();
    step();
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_op_a", op_a, 32'd0);
    check("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    rst = 1'b0;

    // Both operands forwarded from different sources.
    in_valid = 1; asel = 2'b11; bsel = 2'b01; rs1_addr = 5; rs2_addr = 6;
    rs1_data = 32'h1111_1111; rs2_data = 32'h2222_2222;
    set_src(0, 1, 0, 5, 32'hAAAA);
    set_src(1, 1, 0, 6, 32'hBBBB);
    step();
    check("fwd_out_valid", {31'd0, out_valid}, 32'd1);
    check("fwd_op_a", op_a, 32'hAAAA);
    check("fwd_op_b", op_b, 32'hBBBB);
    check("fwd_st_data", st_data, 32'hBBBB);

    // Youngest source wins; x0 never forwards.
    clear_srcs();
    set_src(0, 1, 0, 7, 32'h11);
    set_src(1, 1, 0, 7, 32'h22);
    rs1_addr = 7; rs2_addr = 0; rs2_data = 0; bsel = 2'b10; imm = 32'h55;
    step();
    check("prio_op_a", op_a, 32'h11);
    check("prio_op_b", op_b, 32'h55);
    set_src(0, 1, 0, 0, 32'h33);
    rs1_addr = 0; rs1_data = 0;
    step();
    check("x0_op_a", op_a, 32'h0);

    // Load-use stall on rs1 for three cycles, then release.
    clear_srcs();
    set_src(1, 1, 1, 9, 32'h99);
    rs1_addr = 9; asel = 2'b11; bsel = 2'b00; shamt = 3;
    for (int c = 0; c < 3; c++) begin
      #1 check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    check("stall_cnt3", {16'd0, stall_cnt}, 32'd3);
    src_pending = '0;
    #1 check("release_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("release_op_a", op_a, 32'h99);
    check("release_op_b", op_b, 32'h3);

    // Backpressure holds outputs, then back-to-back transfer.
    clear_srcs();
    out_ready = 0; asel = 2'b01; pc = 32'h200; bsel = 2'b10; imm = 32'h7;
    for (int c = 0; c < 4; c++) begin
      step();
      check("hold_op_a", op_a, 32'h99);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1;
    #1 check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    check("b2b_op_a", op_a, 32'h200);

    // Younger non-pending match masks an older pending one.
    rs2_addr = 4; bsel = 2'b01;
    set_src(0, 1, 0, 4, 32'h44);
    set_src(2, 1, 1, 4, 32'h4444);
    #1 check("mask_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("mask_op_b", op_b, 32'h44);
    // Older pending match now visible: stall on rs2, saturating the narrow counter.
    set_src(0, 0, 0, 0, 32'h0);
    step();
    step();
    check("stall_cnt5", {16'd0, stall_cnt}, 32'd5);
    check("stall_cnt_sat", {30'd0, stall_cnt2}, 32'd3);
    src_pending = '0;
    step();
    check("rs2_op_b", op_b, 32'h4444);
    check("rs2_st_data", st_data, 32'h4444);

    // Flush overrides accept; then pc/shamt selection.
    clear_srcs();
    flush = 1; asel = 2'b10; bsel = 2'b00; pc = 32'h100; shamt = 5'd31;
    step();
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    flush = 0;
    step();
    check("pc_op_a", op_a, 32'h100);
    check("shamt_op_b", op_b, 32'h1F);
    out_ready = 0;

    // Asynchronous reset mid-cycle while holding a bundle.
    #3 rst = 1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_op_a", op_a, 32'd0);
    check("arst_op_b", op_b, 32'd0);
    check("arst_st_data", st_data, 32'd0);
    check("arst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    #1 rst = 0;
    step();
    check("post_rst_accept", {31'd0, out_valid}, 32'd1);
    check("post_rst_op_a", op_a, 32'h100);
    in_valid = 0; out_ready = 1;
    step();
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
